// File: rtl/axis_pkg.sv
// Shared definitions for the stream arbiter and the downstream frame engine:
// arbiter state encoding, frame depth and the clogb2 sizing helper.
package axis_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PASS = 2'b01,
      DROP = 2'b10
   } arb_state_e;

   // Frame depth of the shared engine; the arbiter truncates to this length.
   localparam int FRAME_WORDS = 8;

   // Number of bits needed to represent value (0 -> 0, 1 -> 1, 7 -> 3, 8 -> 4).
   function automatic int clogb2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((value >> i) != 0) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first requester at or above last_grant+1, wrapping modulo
// NUM_SRC. Purely combinational.
module rr_priority_pick
   import axis_pkg::*;
#(
   parameter  int NUM_SRC  = 4,
   localparam int ID_WIDTH = clogb2(NUM_SRC - 1)
) (
   input  logic [NUM_SRC-1:0]  req,
   input  logic [ID_WIDTH-1:0] last_grant,
   output logic [ID_WIDTH-1:0] grant,
   output logic                any_req
);

   logic [ID_WIDTH-1:0] idx;

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = ID_WIDTH'((int'(last_grant) + k) % NUM_SRC);
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            grant   = idx;
         end
      end
   end

endmodule

// File: rtl/axis_frame_rr_arbiter.sv
// Frame-level round-robin arbiter: grants one AXI-Stream source per frame,
// passes its beats to the shared engine and truncates frames beyond MAX_WORDS.
module axis_frame_rr_arbiter
   import axis_pkg::*;
#(
   parameter  int NUM_SRC    = 4,
   parameter  int DATA_WIDTH = 32,
   parameter  int MAX_WORDS  = FRAME_WORDS,
   localparam int ID_WIDTH   = clogb2(NUM_SRC - 1)
) (
   input  logic                          axi_clk,
   input  logic                          axi_reset_n,
   input  logic [NUM_SRC-1:0]            s_axis_valid,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
   input  logic [NUM_SRC-1:0]            s_axis_last,
   output logic [NUM_SRC-1:0]            s_axis_ready,
   output logic                          m_axis_valid,
   output logic [DATA_WIDTH-1:0]         m_axis_data,
   output logic                          m_axis_last,
   input  logic                          m_axis_ready,
   output logic [ID_WIDTH-1:0]           m_axis_id,
   output logic                          busy,
   output logic                          trunc_err
);

   localparam int CNT_WIDTH = clogb2(MAX_WORDS - 1) + 1;

   arb_state_e            state_q, state_d;
   logic [ID_WIDTH-1:0]   grant_q, grant_d;
   logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
   logic [ID_WIDTH-1:0]   pick;
   logic                  any_req;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  trunc_q, trunc_d;
   logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
   logic                  g_valid, g_last, at_max;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign src_data[i] = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_priority_pick #(.NUM_SRC(NUM_SRC)) u_pick (
      .req        (s_axis_valid),
      .last_grant (last_grant_q),
      .grant      (pick),
      .any_req    (any_req)
   );

   assign g_valid = s_axis_valid[grant_q];
   assign g_last  = s_axis_last[grant_q];
   assign at_max  = (count_q == CNT_WIDTH'(MAX_WORDS - 1));

   // NOTE: state uses non-blocking assignments only, and reset is sampled on
   // the clock edge so it shares timing with the downstream engine.
   always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_WIDTH'(NUM_SRC - 1);
         count_q      <= '0;
         trunc_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         count_q      <= count_d;
         trunc_q      <= trunc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      count_d      = count_q;
      trunc_d      = 1'b0;
      s_axis_ready = '0;
      m_axis_valid = 1'b0;
      m_axis_data  = '0;
      m_axis_last  = 1'b0;
      m_axis_id    = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d      = PASS;
               grant_d      = pick;
               last_grant_d = pick;
               count_d      = '0;
            end
         end
         PASS: begin
            m_axis_valid          = g_valid;
            m_axis_data           = src_data[grant_q];
            m_axis_last           = g_last | at_max;
            m_axis_id             = grant_q;
            s_axis_ready[grant_q] = m_axis_ready;
            if (g_valid && m_axis_ready) begin
               count_d = count_q + 1'b1;
               if (g_last) begin
                  state_d = IDLE;
               end else if (at_max) begin
                  state_d = DROP;
                  trunc_d = 1'b1;
               end
            end
         end
         DROP: begin
            // Swallow the tail of an overlong frame up to the source's tlast.
            s_axis_ready[grant_q] = 1'b1;
            if (g_valid && g_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign trunc_err = trunc_q;

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Bench for axis_frame_rr_arbiter: directed scenarios plus a randomized run,
// checked against a frame-level scoreboard and round-robin reference model.
module tb_axis_frame_rr_arbiter;

   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int MAXW = 8;
   localparam int IDW  = 2;

   logic            axi_clk = 1'b0;
   logic            axi_reset_n;
   logic [N-1:0]    s_valid, s_last, s_ready;
   logic [N*DW-1:0] s_data;
   logic            m_valid, m_last, m_ready, busy, trunc_err;
   logic [DW-1:0]   m_data;
   logic [IDW-1:0]  m_id;

   always #5 axi_clk = ~axi_clk;

   axis_frame_rr_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_WORDS(MAXW)) dut (
      .axi_clk      (axi_clk),
      .axi_reset_n  (axi_reset_n),
      .s_axis_valid (s_valid),
      .s_axis_data  (s_data),
      .s_axis_last  (s_last),
      .s_axis_ready (s_ready),
      .m_axis_valid (m_valid),
      .m_axis_data  (m_data),
      .m_axis_last  (m_last),
      .m_axis_ready (m_ready),
      .m_axis_id    (m_id),
      .busy         (busy),
      .trunc_err    (trunc_err)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t        src_q [N][$];
   beat_t        exp_q [$];
   int           grant_log [$];
   int           checks = 0;
   int           errors = 0;
   bit           active;
   int           g, fwd, last_grant;
   bit           trunc_exp;
   logic [N-1:0] ven, hs;
   int           ready_mode;
   bit           bubbles;
   int           beats_out, trunc_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic push_frame(input int src, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = $urandom;
         b.last = (i == len - 1);
         src_q[src].push_back(b);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (ven[i] && src_q[i].size() > 0) begin
            s_valid[i]          = 1'b1;
            s_data[i*DW +: DW]  = src_q[i][0].data;
            s_last[i]           = src_q[i][0].last;
         end else begin
            s_valid[i]          = 1'b0;
            s_data[i*DW +: DW]  = '0;
            s_last[i]           = 1'b0;
         end
      end
   endtask

   // Expected output of a granted frame: its first MAXW beats, tlast on the final one.
   task automatic build_expected(input int src);
      beat_t b;
      for (int i = 0; i < src_q[src].size(); i++) begin
         b      = src_q[src][i];
         b.last = b.last || (i == MAXW - 1);
         exp_q.push_back(b);
         if (b.last) break;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_s_ready"}, 64'(s_ready), 64'(0));
      check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
      check({tag, "_m_data"},  64'(m_data),  64'(0));
      check({tag, "_m_last"},  64'(m_last),  64'(0));
      check({tag, "_m_id"},    64'(m_id),    64'(0));
      check({tag, "_busy"},    64'(busy),    64'(0));
   endtask

   // Runs at the falling edge: compares DUT outputs with the model for the
   // coming rising edge and advances the model across that edge.
   task automatic model_step();
      logic [N-1:0] one_hot;
      bit           trunc_next;
      beat_t        e;
      trunc_next = 1'b0;
      hs         = s_valid & s_ready;
      if (m_valid && m_ready) beats_out++;
      if (trunc_err === 1'b1) trunc_seen++;
      check("trunc_err", 64'(trunc_err), 64'(trunc_exp));
      if (!active) begin
         check_idle_outputs("idle");
         if (|s_valid) begin
            g          = rr_pick(s_valid, last_grant);
            last_grant = g;
            grant_log.push_back(g);
            exp_q.delete();
            build_expected(g);
            active = 1'b1;
            fwd    = 0;
         end
      end else begin
         one_hot    = '0;
         one_hot[g] = 1'b1;
         check("busy", 64'(busy), 64'(1));
         if (fwd < MAXW) begin
            check("pass_s_ready", 64'(s_ready), 64'(m_ready ? one_hot : '0));
            check("pass_m_valid", 64'(m_valid), 64'(s_valid[g]));
            if (s_valid[g]) begin
               if (exp_q.size() == 0) begin
                  check("exp_underflow", 64'(0), 64'(1));
               end else begin
                  e = exp_q[0];
                  check("m_data", 64'(m_data), 64'(e.data));
                  check("m_last", 64'(m_last), 64'(e.last));
                  check("m_id",   64'(m_id),   64'(g));
               end
               if (m_ready) begin
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  fwd++;
                  if (s_last[g]) active = 1'b0;
                  else if (fwd == MAXW) trunc_next = 1'b1;
               end
            end
         end else begin
            check("drop_s_ready", 64'(s_ready), 64'(one_hot));
            check("drop_m_valid", 64'(m_valid), 64'(0));
            if (s_valid[g] && s_last[g]) active = 1'b0;
         end
      end
      trunc_exp = trunc_next;
   endtask

   task automatic env_step();
      for (int i = 0; i < N; i++) begin
         if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (hs[i] || !s_valid[i]) ven[i] = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
      drive();
   endtask

   task automatic cycle();
      @(negedge axi_clk);
      model_step();
      @(posedge axi_clk);
      #1;
      env_step();
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run_until_quiet(input int budget, input string tag);
      int n;
      n = 0;
      while ((pending() || active) && n < budget) begin
         cycle();
         n++;
      end
      check({tag, "_timeout"}, 64'(n < budget), 64'(1));
      cycle();
      cycle();
   endtask

   task automatic do_reset(input int n);
      axi_reset_n = 1'b0;
      drive();
      repeat (n) begin
         @(posedge axi_clk);
         #1;
         @(negedge axi_clk);
         check_idle_outputs("reset");
         check("reset_trunc", 64'(trunc_err), 64'(0));
      end
      active     = 1'b0;
      last_grant = N - 1;
      trunc_exp  = 1'b0;
      fwd        = 0;
      exp_q.delete();
      @(posedge axi_clk);
      #1;
      axi_reset_n = 1'b1;
      drive();
   endtask

   task automatic start_test();
      beats_out  = 0;
      trunc_seen = 0;
      grant_log.delete();
   endtask

   initial begin
      int n;
      ven        = '1;
      hs         = '0;
      bubbles    = 1'b0;
      ready_mode = 0;
      m_ready    = 1'b1;
      s_valid    = '0;
      s_last     = '0;
      s_data     = '0;
      do_reset(3);

      // 1: single 3-word frame from source 0
      start_test();
      push_frame(0, 3);
      drive();
      run_until_quiet(100, "t1");
      check("t1_beats", 64'(beats_out), 64'(3));
      check("t1_trunc", 64'(trunc_seen), 64'(0));
      check("t1_grant", 64'(grant_log[0]), 64'(0));

      // 2: all sources request 2-word frames; rotation 0,1,2,3,0
      do_reset(1);
      start_test();
      for (int i = 0; i < N; i++) push_frame(i, 2);
      push_frame(0, 2);
      drive();
      run_until_quiet(200, "t2");
      check("t2_frames", 64'(grant_log.size()), 64'(5));
      for (int i = 0; i < 5 && i < grant_log.size(); i++)
         check($sformatf("t2_order%0d", i), 64'(grant_log[i]), 64'(i % N));

      // 3: source 1, 5 words, m_axis_ready toggling
      start_test();
      ready_mode = 1;
      push_frame(1, 5);
      drive();
      run_until_quiet(200, "t3");
      check("t3_beats", 64'(beats_out), 64'(5));
      ready_mode = 0;
      m_ready    = 1'b1;

      // 4: source 2, 10 words -> truncated at 8
      start_test();
      push_frame(2, 10);
      drive();
      run_until_quiet(200, "t4");
      check("t4_beats", 64'(beats_out), 64'(8));
      check("t4_trunc", 64'(trunc_seen), 64'(1));

      // 5: source 3, exactly 8 words -> no truncation
      start_test();
      push_frame(3, 8);
      drive();
      run_until_quiet(200, "t5");
      check("t5_beats", 64'(beats_out), 64'(8));
      check("t5_trunc", 64'(trunc_seen), 64'(0));

      // 6: reset after beat 2 of a source-1 frame
      start_test();
      push_frame(1, 6);
      drive();
      n = 0;
      while (fwd < 2 && n < 50) begin
         cycle();
         n++;
      end
      check("t6_wait_timeout", 64'(n < 50), 64'(1));
      for (int i = 0; i < N; i++) src_q[i].delete();
      push_frame(0, 3);
      push_frame(1, 3);
      grant_log.delete();
      do_reset(2);
      run_until_quiet(200, "t6");
      check("t6_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));

      // Randomized traffic: random sources, lengths, bubbles and backpressure
      start_test();
      bubbles    = 1'b1;
      ready_mode = 2;
      for (int f = 0; f < 40; f++) push_frame($urandom_range(0, N - 1), $urandom_range(1, 12));
      drive();
      run_until_quiet(20000, "rand");
      check("rand_frames", 64'(grant_log.size()), 64'(40));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_frame_rr_arbiter.md
Name: axis_frame_rr_arbiter

Overview:
- Frame-level round-robin arbiter that shares one downstream AXI4-Stream processing block (e.g. the 8-word store/execute/send frame engine) between NUM_SRC upstream stream sources.
- Grants one source per frame, passes its beats through unchanged with a source tag, and holds the grant until tlast.
- Enforces a maximum frame length: an overlong frame gets a forced tlast, and the remainder of that frame is discarded.
- Sits between the DMA/stream sources and the shared engine.

Parameters:
- NUM_SRC, 4, number of requesting slave streams (2..8)
- DATA_WIDTH, 32, tdata width per stream
- MAX_WORDS, 8, maximum beats forwarded per frame (must match the downstream engine's frame depth)
- ID_WIDTH (localparam), clogb2(NUM_SRC-1), width of the source tag

Ports:
- axi_clk  in  1  single clock; all logic rising-edge
- axi_reset_n  in  1  synchronous active-low reset
- s_axis_valid  in  NUM_SRC  per-source tvalid
- s_axis_data  in  NUM_SRC*DATA_WIDTH  per-source tdata; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_last  in  NUM_SRC  per-source tlast
- s_axis_ready  out  NUM_SRC  per-source tready
- m_axis_valid  out  1  tvalid to shared engine
- m_axis_data  out  DATA_WIDTH  tdata to shared engine
- m_axis_last  out  1  tlast to shared engine (source tlast, or forced at MAX_WORDS)
- m_axis_ready  in  1  tready from shared engine
- m_axis_id  out  ID_WIDTH  index of the granted source, valid with m_axis_valid
- busy  out  1  high in PASS and DROP
- trunc_err  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset (axi_reset_n low at a clock edge):
  - state=IDLE, grant_id=0, beat count=0.
  - Round-robin pointer last_grant=NUM_SRC-1, so source 0 has first priority.
  - Outputs: all s_axis_ready=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0, m_axis_id=0, busy=0, trunc_err=0.
  - Reset mid-frame abandons the frame with no tlast emitted; the downstream engine is reset by the same signal.
- States: IDLE, PASS, DROP.
- IDLE:
  - All ready=0, m_axis_valid=0.
  - If any s_axis_valid is high, grant the first requester searching upward from last_grant+1, wrapping modulo NUM_SRC.
  - Register grant_id and last_grant; count=0; next state PASS.
  - Arbitration costs exactly 1 cycle. The earliest output beat is the cycle after the request is seen.
- PASS (combinational pass-through of the granted source g):
  - m_axis_valid=s_axis_valid[g]; m_axis_data=s_axis_data[g]; m_axis_id=g.
  - s_axis_ready[g]=m_axis_ready; all other ready=0.
  - m_axis_last=s_axis_last[g] OR (count==MAX_WORDS-1).
  - A handshake (valid&&ready) increments count.
  - Handshake with s_axis_last[g] (regardless of count) -> IDLE.
  - Handshake at count==MAX_WORDS-1 without s_axis_last[g] -> DROP, and trunc_err pulses on the following cycle.
- DROP:
  - s_axis_ready[g]=1; m_axis_valid=0.
  - Incoming beats are discarded.
  - Handshake with s_axis_last[g] -> IDLE.
- m_axis_valid never depends on m_axis_ready.
- While m_axis_valid is high and m_axis_ready is low, data/last/id stay stable because the source must hold them per AXI.
- Non-granted sources see ready=0 and stall. A requester that drops valid before grant is simply skipped.
- Count width is clogb2(MAX_WORDS-1)+1; the count never wraps within a frame.
- A frame of exactly MAX_WORDS beats with source tlast on the last beat is not a truncation (trunc_err stays 0).
- Minimum gap between frames is 1 cycle (IDLE).
- Fairness: with all sources requesting continuously, grants rotate 0,1,...,NUM_SRC-1,0.

Decomposition:
- Shared package axis_pkg holds:
  - state encoding (IDLE=2'b00, PASS=2'b01, DROP=2'b10)
  - the clogb2 function
  - the default MAX_WORDS constant shared with the frame engine
- One combinational sub-module, rr_priority_pick (NUM_SRC, req vector, last_grant in -> grant index plus any_req out), instantiated once.

Test Plan:
1. Source 0 alone sends 3-word frame A,B,C with tlast on C, m_axis_ready=1 -> m beats A,B,C; id=0; last only on C; busy falls the cycle after C; trunc_err=0.
2. All 4 sources hold valid with 2-word frames -> frames emerge in id order 0,1,2,3,0; each id is constant within its frame; one idle cycle between frames.
3. Source 1 frame of 5 words with m_axis_ready toggling 1,0,1,0 -> exactly 5 beats in order, no duplicates; s_axis_ready[1] mirrors m_axis_ready; other sources' ready stays 0.
4. Source 2 sends 10 words with tlast on word 10, MAX_WORDS=8 -> 8 beats out with last on beat 8; 1-cycle trunc_err pulse; words 9-10 consumed with no m_axis_valid; then returns to IDLE.
5. Source 3 sends exactly 8 words with tlast on word 8 -> 8 beats, last on beat 8, trunc_err=0.
6. Reset asserted after beat 2 of a source-1 frame -> next cycle all outputs are 0; after release with sources 0 and 1 requesting, source 0 is granted first.
